// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode constants used by the
// fetch unit and the control unit, and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;

  // Primary opcode field values (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Extract the primary opcode field from an instruction word.
  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for an accepted instruction:
// jump (region-relative word index) beats taken branch (PC-relative
// word offset), otherwise fall through to the next sequential word.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  instr_pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               jump,
  input  logic               alu_zero,
  output logic [ADDR_W-1:0]  next_pc
);

  // Upper address bits kept from pc4 on a jump; the low 28 bits come
  // from the instruction's 26-bit word index.
  localparam logic [ADDR_W-1:0] REGION_MASK = ~ADDR_W'(32'h0FFF_FFFF);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] branch_target;
  logic [5:0]        unused_opcode;

  assign pc4           = instr_pc + ADDR_W'(4);
  assign jump_target   = (pc4 & REGION_MASK) | ADDR_W'({instr[25:0], 2'b00});
  // Sign-extend to 32 bits first, then truncate; wraps modulo 2^ADDR_W.
  assign branch_offset = ADDR_W'({{14{instr[15]}}, instr[15:0], 2'b00});
  assign branch_target = pc4 + branch_offset;
  assign unused_opcode = instr[31:26];

  // Priority select: jump, then taken branch, then sequential.
  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && alu_zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding word
// reads to instruction memory, holds each fetched instruction for decode
// under valid/ready, and selects the next PC from decode's branch/jump
// decision at accept time.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               arst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               jump,
  input  logic               alu_zero,
  output logic [31:0]        retired,
  output logic               imem_err
);

  // Fetch addresses are always word aligned.
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & ~ADDR_W'(3);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_calc (
    .instr_pc (instr_pc),
    .instr    (instr),
    .branch   (branch),
    .jump     (jump),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  assign imem_addr = pc;
  assign opcode    = opcode_of(instr);

  // Fetch sequencer with registered handshake outputs. FETCH lasts one
  // request cycle; straight out of reset it first spends a cycle raising
  // imem_req. An accept re-enters FETCH with imem_req already set so the
  // new PC is requested in the very next cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC_ALIGNED;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      retired     <= '0;
      imem_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_FETCH: begin
          // Data cannot legally arrive in the request cycle; flag and drop it.
          if (imem_rvalid) begin
            imem_err <= 1'b1;
          end
          if (imem_req) begin
            imem_req <= 1'b0;
            state    <= ST_WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // No read is outstanding here; stray data is flagged and dropped.
          if (imem_rvalid) begin
            imem_err <= 1'b1;
          end
          if (instr_ready) begin
            pc          <= next_pc;
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= ST_FETCH;
          end
        end

        default: begin
          imem_req <= 1'b0;
          state    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a latency-1 memory model
// driven from the stimulus tasks.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        br;
    logic        jp;
    logic        z;
    logic [31:0] next;
  } vec_t;

  logic        clk;
  logic        arst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        jump;
  logic        alu_zero;
  logic [31:0] retired;
  logic        imem_err;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  vec_t tab_a[14];
  vec_t tab_b[2];

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .jump        (jump),
    .alu_zero    (alu_zero),
    .retired     (retired),
    .imem_err    (imem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a read request; called at a negedge.
  task automatic wait_req(input string name);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " req"}, {31'd0, imem_req}, 32'd1);
  endtask

  // One full fetch/accept transaction with latency-1 memory.
  task automatic run_vec(input vec_t v, input string name);
    wait_req(name);
    check({name, " addr"}, imem_addr, v.pc);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = v.word;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);
    check({name, " valid"}, {31'd0, instr_valid}, 32'd1);
    check({name, " instr"}, instr, v.word);
    check({name, " opcode"}, {26'd0, opcode}, {26'd0, v.word[31:26]});
    check({name, " instr_pc"}, instr_pc, v.pc);
    check({name, " no_req"}, {31'd0, imem_req}, 32'd0);
    branch      = v.br;
    jump        = v.jp;
    alu_zero    = v.z;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_zero    = 1'b0;
    exp_retired++;
    @(negedge clk);
    check({name, " next_req"}, {31'd0, imem_req}, 32'd1);
    check({name, " next_addr"}, imem_addr, v.next);
    check({name, " retired"}, retired, exp_retired);
    check({name, " valid_drop"}, {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " req"}, {31'd0, imem_req}, 32'd0);
    check({name, " addr"}, imem_addr, 32'h0);
    check({name, " instr"}, instr, 32'h0);
    check({name, " opcode"}, {26'd0, opcode}, 32'h0);
    check({name, " instr_pc"}, instr_pc, 32'h0);
    check({name, " valid"}, {31'd0, instr_valid}, 32'd0);
    check({name, " retired"}, retired, 32'd0);
    check({name, " err"}, {31'd0, imem_err}, 32'd0);
  endtask

  initial begin
    // Sequential, branch and jump vectors from reset.
    tab_a[0]  = '{32'h0000_0000, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
    tab_a[1]  = '{32'h0000_0004, 32'h2001_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
    tab_a[2]  = '{32'h0000_0008, 32'h8C22_0004, 1'b0, 1'b0, 1'b0, 32'h0000_000C};
    tab_a[3]  = '{32'h0000_000C, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
    tab_a[4]  = '{32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_000C};
    tab_a[5]  = '{32'h0000_000C, 32'h0800_0004, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
    tab_a[6]  = '{32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    tab_a[7]  = '{32'h0000_0014, 32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC};
    tab_a[8]  = '{32'h0FFF_FFFC, 32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h1000_0040};
    tab_a[9]  = '{32'h1000_0040, 32'h0800_0100, 1'b0, 1'b1, 1'b0, 32'h1000_0400};
    tab_a[10] = '{32'h1000_0400, 32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h1000_0040};
    tab_a[11] = '{32'h1000_0040, 32'h0800_0100, 1'b1, 1'b1, 1'b1, 32'h1000_0400};
    tab_a[12] = '{32'h1000_0400, 32'h1000_0003, 1'b1, 1'b0, 1'b1, 32'h1000_0410};
    tab_a[13] = '{32'h1000_0410, 32'h1000_0005, 1'b0, 1'b0, 1'b1, 32'h1000_0414};
    // After a second reset: backward branch across zero, then wrap.
    tab_b[0]  = '{32'h0000_0000, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};
    tab_b[1]  = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

    arst_n      = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_zero    = 1'b0;

    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    for (int i = 0; i < 14; i++) begin
      run_vec(tab_a[i], $sformatf("a%0d", i));
    end
    check("no_err_after_table", {31'd0, imem_err}, 32'd0);

    // Backpressure in HOLD with a stray rvalid injected mid-stall.
    wait_req("bp");
    check("bp addr", imem_addr, 32'h1000_0414);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h8C22_0008;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d instr", c), instr, 32'h8C22_0008);
      check($sformatf("bp%0d instr_pc", c), instr_pc, 32'h1000_0414);
      check($sformatf("bp%0d valid", c), {31'd0, instr_valid}, 32'd1);
      check($sformatf("bp%0d no_req", c), {31'd0, imem_req}, 32'd0);
      if (c >= 2) begin
        check($sformatf("bp%0d err", c), {31'd0, imem_err}, 32'd1);
      end
      if (c == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    exp_retired++;
    @(negedge clk);
    check("bp release req", {31'd0, imem_req}, 32'd1);
    check("bp release addr", imem_addr, 32'h1000_0418);
    check("bp retired", retired, exp_retired);
    check("err sticky", {31'd0, imem_err}, 32'd1);

    // Asynchronous reset while waiting for read data.
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("mid_wait_rst");
    exp_retired = 0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_release req", {31'd0, imem_req}, 32'd1);
    check("rst_release addr", imem_addr, 32'h0);

    for (int i = 0; i < 2; i++) begin
      run_vec(tab_b[i], $sformatf("b%0d", i));
    end
    check("no_err_after_b", {31'd0, imem_err}, 32'd0);

    // Stray rvalid during the request cycle: flagged, then normal fetch.
    wait_req("fetch_err");
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);
    check("fetch_err err", {31'd0, imem_err}, 32'd1);
    check("fetch_err no_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hAC22_0010;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);
    check("fetch_err valid", {31'd0, instr_valid}, 32'd1);
    check("fetch_err instr", instr, 32'hAC22_0010);
    check("fetch_err opcode", {26'd0, opcode}, 32'h0000_002B);
    check("fetch_err instr_pc", instr_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer that sits upstream of the instruction decoder and control unit. It owns the program counter, issues word reads to instruction memory over a request/valid handshake, and presents each fetched instruction with its opcode field to decode under a valid/ready handshake. It consumes the `branch`, `jump` and ALU `zero` decisions that decode returns to select the next PC.

## Interface
- `ADDR_W`, default 32: PC and instruction-address width; legal range 28..32.
- `RESET_PC`, default 0: first fetch address; bits [1:0] are forced to 0.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `arst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: one-cycle read request.
- `imem_addr` out ADDR_W: word-aligned read address, always equal to the PC register.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: held instruction.
- `opcode` out 6: `instr[31:26]`, fed to the control unit.
- `instr_pc` out ADDR_W: address of `instr`.
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `branch` in 1: decode flag for the presented instruction.
- `jump` in 1: decode flag for the presented instruction.
- `alu_zero` in 1: datapath zero flag; sampled only on accept.
- `retired` out 32: count of accepted instructions; wraps modulo 2^32.
- `imem_err` out 1: sticky flag for an unexpected `imem_rvalid`.

## Operation
- FSM has three states: FETCH, WAIT, HOLD.
  - FETCH: `imem_req`=1 for exactly one cycle; then go to WAIT.
  - WAIT: on `imem_rvalid`, capture `imem_rdata` into `instr`, capture PC into `instr_pc`, and go to HOLD. With no `imem_rvalid`, stay in WAIT indefinitely.
  - HOLD: `instr_valid`=1. On `instr_valid && instr_ready` (accept), load PC with the next PC, increment `retired`, and go to FETCH. Without `instr_ready`, `instr`, `instr_pc` and `opcode` stay stable.
- Next-PC selection at accept. Here `pc4 = instr_pc + 4`, computed modulo 2^ADDR_W.
  - If `jump`=1: `{pc4[ADDR_W-1:28], instr[25:0], 2'b00}`. Jump has priority over branch.
  - Else if `branch && alu_zero`: `pc4 + (sign_extend(instr[15:0]) << 2)`, modulo 2^ADDR_W.
  - Otherwise: `pc4`.
- `branch`, `jump` and `alu_zero` are ignored outside the accept cycle.
- `imem_rvalid` in FETCH or HOLD sets `imem_err`; the data is discarded and the state is unchanged. Only reset clears `imem_err`.
- The unit is single-outstanding: at most one read is in flight, and there is no prefetch.

## Timing
- Reset values, applied asynchronously: state=FETCH, PC=`RESET_PC`. All of these are 0: `imem_req`, `instr`, `opcode`, `instr_pc`, `instr_valid`, `retired`, `imem_err`.
- `imem_req` is a registered decode of state. It is first asserted in the first clock cycle after `arst_n` deasserts.
- Memory latency is at least 1 cycle: `imem_rvalid` is legal from the cycle after `imem_req` onward.
- `instr_valid` rises in the cycle after the cycle in which `imem_rvalid` is seen.
- After an accept at cycle N, the new PC appears on `imem_addr` and `imem_req`=1 at cycle N+1.
- Best-case throughput, with latency 1 and `instr_ready` tied high, is one instruction per 3 cycles.
- If reset asserts mid-read, any later `imem_rvalid` from the aborted read arrives in FETCH or WAIT:
  - In FETCH it sets `imem_err`.
  - In WAIT it is indistinguishable from valid data. The memory must therefore also be reset by `arst_n`.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (R-type 0x00, J 0x02, BEQ 0x04, ADDI 0x08, LW 0x23, SW 0x2B), shared with the control unit;
  - the fetch state enum;
  - the width constant `INSTR_W`=32.
- Sub-module `next_pc_calc` (combinational) takes `instr_pc`, `instr`, `branch`, `jump` and `alu_zero`, and produces the next PC. It is instantiated once.

## Test plan
- Reset:
  - Drop `arst_n` while in WAIT → all outputs read 0 immediately, `imem_addr`=`RESET_PC`.
  - After release → `imem_req`=1 at `imem_addr`=0x0 on the first cycle.
- Sequential fetch: latency 1, `instr_ready`=1, no branches → `imem_addr` sequence 0x0, 0x4, 0x8, `imem_req` every 3rd cycle, `retired`=3 after the third accept.
- Branch at `instr_pc`=0x10 with `instr[15:0]`=0xFFFE:
  - `branch`=1, `alu_zero`=1 → next `imem_addr`=0x0C.
  - `branch`=1, `alu_zero`=0 → next `imem_addr`=0x14.
- Jump at `instr_pc`=0x1000_0040, `instr`=0x0800_0100:
  - `jump`=1 → next `imem_addr`=0x1000_0400.
  - `jump`=1 with `branch`=`alu_zero`=1 → still 0x1000_0400.
- Backpressure: hold `instr_ready`=0 for 5 cycles in HOLD → `instr`/`instr_pc` stable, no `imem_req`. Raise `instr_ready` → `imem_req` on the next cycle.
- Boundaries:
  - PC=0xFFFF_FFFC, sequential → next `imem_addr`=0x0000_0000.
  - Inject `imem_rvalid` while in HOLD → `imem_err`=1, `instr` unchanged.
